// File: rtl/image_mode_sequencer_pkg.sv
// Shared types for the image mode sequencer: pipeline modes, sequencer states
// and the mode-to-pipeline-control mapping.
package img_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY  = 2'd0,
        MODE_HEDGE = 2'd1,
        MODE_VEDGE = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } seq_state_e;

    // Plain-vector state codes so the state register stays a logic vector.
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_PEND  = PEND;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    localparam logic [1:0] SW_ILLEGAL = 2'd3;

    // Returns {grayscale_cs, h_edgeDetect}.
    function automatic logic [1:0] mode_to_ctrl(input mode_e mode);
        case (mode)
            MODE_HEDGE: return 2'b11;
            MODE_VEDGE: return 2'b10;
            default:    return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/image_mode_sequencer_if.sv
// Camera timing, user controls and pipeline mode outputs of the image mode sequencer.
interface image_mode_sequencer_if #(
    parameter int FRAME_CNT_W = 16
);
    logic                   iFVAL;
    logic                   iLVAL;
    logic [1:0]             iSW_mode;
    logic                   iKEY_apply;
    logic                   grayscale_cs;
    logic                   h_edgeDetect;
    logic                   oBlank;
    logic                   oBusy;
    logic                   oReq_err;
    logic [FRAME_CNT_W-1:0] oFrame_cnt;

    modport master (
        output iFVAL, iLVAL, iSW_mode, iKEY_apply,
        input  grayscale_cs, h_edgeDetect, oBlank, oBusy, oReq_err, oFrame_cnt
    );

    modport slave (
        input  iFVAL, iLVAL, iSW_mode, iKEY_apply,
        output grayscale_cs, h_edgeDetect, oBlank, oBusy, oReq_err, oFrame_cnt
    );
endinterface

// File: rtl/image_mode_sequencer_key_conditioner.sv
// Turns the asynchronous active-low apply key into a one-cycle press pulse.
// Define KEY_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable-low cycles per press.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic press_q;
    logic press_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            press_q <= press_d;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             armed_q;
    logic             armed_d;

    // One pulse on the last of DEBOUNCE_CYCLES low cycles; re-armed only by a release.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        press_d = 1'b0;
        if (sync2_q) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (cnt_q == CNT_LAST) begin
                press_d = 1'b1;
                armed_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end
`else
    logic prev_q;

    always_comb begin
        press_d = prev_q & ~sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sync2_q;
        end
    end

    // DEBOUNCE_CYCLES has no effect without the debounce counter.
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_unused
    end
`endif

    assign press = press_q;

endmodule

// File: rtl/image_mode_sequencer.sv
// Frame-synchronous mode sequencer for the grayscale/Sobel pipeline.
// Build option KEY_DEBOUNCE_EN enables the apply-key debounce in key_conditioner.
module image_mode_sequencer
    import img_ctrl_pkg::*;
#(
    parameter int FLUSH_LINES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FRAME_CNT_W     = 16
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    image_mode_sequencer_if.slave bus
);

    localparam logic [3:0] LAST_LINE = 4'(FLUSH_LINES - 1);

    logic                   press;
    logic                   fval_q, fval_prev_q;
    logic                   lval_q, lval_prev_q;
    logic                   frame_start, line_end;
    logic                   req_legal;
    mode_e                  req_mode;

    logic [1:0]             state_q, state_d;
    mode_e                  active_q, active_d;
    mode_e                  pend_q, pend_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [3:0]             line_cnt_q, line_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]             ctrl_q, ctrl_d;
    logic                   blank_q, blank_d;
    logic                   busy_q, busy_d;
    logic                   req_err_q, req_err_d;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_conditioner (
        .clk   (iCLK),
        .rst   (iRST),
        .key_n (bus.iKEY_apply),
        .press (press)
    );

    always_comb begin
        frame_start = fval_q & ~fval_prev_q;
        line_end    = lval_prev_q & ~lval_q;
        req_legal   = press & (bus.iSW_mode != SW_ILLEGAL);
        req_mode    = mode_e'(bus.iSW_mode);
    end

    // A commit always takes the pending value held before any same-cycle press.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        line_cnt_d  = line_cnt_q;
        frame_cnt_d = frame_start ? frame_cnt_q + FRAME_CNT_W'(1) : frame_cnt_q;
        req_err_d   = press & (bus.iSW_mode == SW_ILLEGAL);

        case (state_q)
            ST_RUN: begin
                if (req_legal && (req_mode != active_q)) begin
                    pend_d  = req_mode;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (frame_start) begin
                    active_d   = pend_q;
                    line_cnt_d = '0;
                    state_d    = ST_FLUSH;
                    pend_vld_d = req_legal;
                    if (req_legal) begin
                        pend_d = req_mode;
                    end
                end else if (req_legal) begin
                    if (req_mode == active_q) begin
                        state_d = ST_RUN;
                    end else begin
                        pend_d = req_mode;
                    end
                end
            end
            ST_FLUSH: begin
                if (req_legal) begin
                    pend_d     = req_mode;
                    pend_vld_d = 1'b1;
                end
                if (frame_start) begin
                    line_cnt_d = '0;
                    if (pend_vld_q) begin
                        active_d   = pend_q;
                        pend_vld_d = req_legal;
                    end
                end else if (line_end) begin
                    if (line_cnt_q == LAST_LINE) begin
                        state_d    = (pend_vld_q || req_legal) ? ST_PEND : ST_RUN;
                        pend_vld_d = 1'b0;
                    end else if (line_cnt_q != 4'hF) begin
                        line_cnt_d = line_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase

        ctrl_d  = mode_to_ctrl(active_d);
        blank_d = (state_d == ST_FLUSH);
        busy_d  = (state_d != ST_RUN);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fval_q      <= 1'b0;
            fval_prev_q <= 1'b0;
            lval_q      <= 1'b0;
            lval_prev_q <= 1'b0;
            state_q     <= ST_FLUSH;
            active_q    <= MODE_GRAY;
            pend_q      <= MODE_GRAY;
            pend_vld_q  <= 1'b0;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            ctrl_q      <= 2'b00;
            blank_q     <= 1'b1;
            busy_q      <= 1'b1;
            req_err_q   <= 1'b0;
        end else begin
            fval_q      <= bus.iFVAL;
            fval_prev_q <= fval_q;
            lval_q      <= bus.iLVAL;
            lval_prev_q <= lval_q;
            state_q     <= state_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            line_cnt_q  <= line_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ctrl_q      <= ctrl_d;
            blank_q     <= blank_d;
            busy_q      <= busy_d;
            req_err_q   <= req_err_d;
        end
    end

    assign bus.grayscale_cs = ctrl_q[1];
    assign bus.h_edgeDetect = ctrl_q[0];
    assign bus.oBlank       = blank_q;
    assign bus.oBusy        = busy_q;
    assign bus.oReq_err     = req_err_q;
    assign bus.oFrame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_image_mode_sequencer.sv
// Scoreboard bench for image_mode_sequencer: every output change is matched, in order and
// within its stimulus phase, against hand-written expectations queued by the stimulus.
module tb_image_mode_sequencer;

`ifdef KEY_DEBOUNCE_EN
    localparam int PRESS_LAT = 10;
    localparam int KEY_HOLD  = 12;
`else
    localparam int PRESS_LAT = 3;
    localparam int KEY_HOLD  = 4;
`endif

    typedef struct packed {
        logic        cs;
        logic        h;
        logic        blank;
        logic        busy;
        logic        err;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        obs_t v;
        int   ph;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   checks = 0;
    int   passes = 0;
    int   phase  = 0;
    exp_t exp_q[$];
    int   wrap_q[$];

    image_mode_sequencer_if #(.FRAME_CNT_W(16)) bus_if ();
    image_mode_sequencer_if #(.FRAME_CNT_W(4))  wrap_if ();

    image_mode_sequencer #(
        .FLUSH_LINES     (2),
        .DEBOUNCE_CYCLES (8),
        .FRAME_CNT_W     (16)
    ) u_dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus_if)
    );

    image_mode_sequencer #(
        .FLUSH_LINES     (2),
        .DEBOUNCE_CYCLES (8),
        .FRAME_CNT_W     (4)
    ) u_dut_wrap (
        .iCLK (clk),
        .iRST (rst),
        .bus  (wrap_if)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic next_phase();
        phase = phase + 1;
    endtask

    task automatic expect_out(input logic cs, input logic h, input logic blank,
                              input logic busy, input logic err, input int fc);
        exp_t e;
        e.v  = {cs, h, blank, busy, err, 16'(fc)};
        e.ph = phase;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input obs_t got, input int ph);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL out_unexpected: got cs=%0b h=%0b blank=%0b busy=%0b err=%0b fc=%0d in phase %0d, required no change",
                     got.cs, got.h, got.blank, got.busy, got.err, got.fc, ph);
            return;
        end
        e = exp_q.pop_front();
        if (got !== e.v || ph != e.ph) begin
            $display("[TB] FAIL out_seq: got cs=%0b h=%0b blank=%0b busy=%0b err=%0b fc=%0d phase %0d, required cs=%0b h=%0b blank=%0b busy=%0b err=%0b fc=%0d phase %0d",
                     got.cs, got.h, got.blank, got.busy, got.err, got.fc, ph,
                     e.v.cs, e.v.h, e.v.blank, e.v.busy, e.v.err, e.v.fc, e.ph);
        end else begin
            passes++;
        end
    endtask

    task automatic frame_begin();
        bus_if.iFVAL = 1'b1;
        tick(4);
    endtask

    task automatic frame_end();
        bus_if.iFVAL = 1'b0;
        tick(2);
    endtask

    task automatic do_line();
        bus_if.iLVAL = 1'b1;
        tick(4);
        bus_if.iLVAL = 1'b0;
        tick(4);
    endtask

    task automatic press(input logic [1:0] sw);
        bus_if.iSW_mode   = sw;
        bus_if.iKEY_apply = 1'b0;
        tick(KEY_HOLD);
        bus_if.iKEY_apply = 1'b1;
        tick(4);
    endtask

    // Key falls so that the press pulse lands in the same cycle as frame_start.
    task automatic press_at_frame_start(input logic [1:0] sw);
        bus_if.iSW_mode   = sw;
        bus_if.iKEY_apply = 1'b0;
        tick(PRESS_LAT - 1);
        bus_if.iFVAL = 1'b1;
        tick(4);
        bus_if.iKEY_apply = 1'b1;
        tick(4);
    endtask

    task automatic applyStimulus();
        // Reset, then two lines finish the initial flush in GRAY
        next_phase(); expect_out(0, 0, 1, 1, 0, 1); frame_begin();
        next_phase(); do_line();
        next_phase(); expect_out(0, 0, 0, 0, 0, 1); do_line();
        // Illegal request: single error pulse, nothing else moves
        next_phase(); expect_out(0, 0, 0, 0, 1, 1); expect_out(0, 0, 0, 0, 0, 1); press(2'd3);
        // HEDGE then VEDGE before the frame start: only VEDGE is committed
        next_phase(); expect_out(0, 0, 0, 1, 0, 1); press(2'd1);
        next_phase(); press(2'd2);
        next_phase(); do_line();
        next_phase(); frame_end();
        next_phase(); expect_out(1, 0, 1, 1, 0, 2); frame_begin();
        next_phase(); do_line();
        next_phase(); expect_out(1, 0, 0, 0, 0, 2); do_line();
        // Mid-frame HEDGE request waits for the next frame start
        next_phase(); expect_out(1, 0, 0, 1, 0, 2); press(2'd1);
        next_phase(); do_line();
        next_phase(); frame_end();
        next_phase(); expect_out(1, 1, 1, 1, 0, 3); frame_begin();
        // Request during the flush leaves the sequencer in PEND afterwards
        next_phase(); press(2'd2);
        next_phase(); do_line();
        next_phase(); expect_out(1, 1, 0, 1, 0, 3); do_line();
        next_phase(); frame_end();
        next_phase(); expect_out(1, 0, 1, 1, 0, 4); frame_begin();
        next_phase(); do_line();
        next_phase(); expect_out(1, 0, 0, 0, 0, 4); do_line();
        // Request equal to the active mode is ignored in RUN and cancels in PEND
        next_phase(); press(2'd2);
        next_phase(); expect_out(1, 0, 0, 1, 0, 4); press(2'd0);
        next_phase(); expect_out(1, 0, 0, 0, 0, 4); press(2'd2);
        // Frame start inside a flush commits the pending mode and restarts the line count
        next_phase(); expect_out(1, 0, 0, 1, 0, 4); press(2'd0);
        next_phase(); frame_end();
        next_phase(); expect_out(0, 0, 1, 1, 0, 5); frame_begin();
        next_phase(); press(2'd1);
        next_phase(); do_line();
        next_phase(); frame_end();
        next_phase(); expect_out(1, 1, 1, 1, 0, 6); frame_begin();
        next_phase(); do_line();
        next_phase(); expect_out(1, 1, 0, 0, 0, 6); do_line();
        // Press coinciding with frame start: old pending commits, new one waits a frame
        next_phase(); expect_out(1, 1, 0, 1, 0, 6); press(2'd2);
        next_phase(); frame_end();
        next_phase(); expect_out(1, 0, 1, 1, 0, 7); press_at_frame_start(2'd0);
        next_phase(); do_line();
        next_phase(); expect_out(1, 0, 0, 1, 0, 7); do_line();
        next_phase(); frame_end();
        next_phase(); expect_out(0, 0, 1, 1, 0, 8); frame_begin();
        next_phase(); do_line();
        next_phase(); expect_out(0, 0, 0, 0, 0, 8); do_line();
`ifdef KEY_DEBOUNCE_EN
        // A 5-cycle glitch is rejected; a 10-cycle low gives one press
        next_phase();
        bus_if.iSW_mode   = 2'd3;
        bus_if.iKEY_apply = 1'b0;
        tick(5);
        bus_if.iKEY_apply = 1'b1;
        tick(6);
        next_phase(); expect_out(0, 0, 0, 0, 1, 8); expect_out(0, 0, 0, 0, 0, 8);
        bus_if.iKEY_apply = 1'b0;
        tick(10);
        bus_if.iKEY_apply = 1'b1;
        tick(6);
`endif
    endtask

    initial begin : monitor_main
        obs_t last;
        obs_t cur;
        bit   first;
        first = 1'b1;
        @(negedge rst);
        forever begin
            @(negedge clk);
            cur = {bus_if.grayscale_cs, bus_if.h_edgeDetect, bus_if.oBlank,
                   bus_if.oBusy, bus_if.oReq_err, bus_if.oFrame_cnt};
            if (first || cur !== last) begin
                checkOutput(cur, phase);
                last  = cur;
                first = 1'b0;
            end
        end
    end

    initial begin : monitor_wrap
        logic [3:0] last;
        logic [3:0] cur;
        int         want;
        @(negedge rst);
        @(negedge clk);
        last = wrap_if.oFrame_cnt;
        forever begin
            @(negedge clk);
            cur = wrap_if.oFrame_cnt;
            if (cur !== last) begin
                checks++;
                if (wrap_q.size() == 0) begin
                    $display("[TB] FAIL wrap_unexpected: got frame count %0d, required no change", cur);
                end else begin
                    want = wrap_q.pop_front();
                    if (cur !== 4'(want)) begin
                        $display("[TB] FAIL wrap_cnt: got %0d, required %0d", cur, want);
                    end else begin
                        passes++;
                    end
                end
                last = cur;
            end
        end
    end

    initial begin : stimulus
        bus_if.iFVAL       = 1'b0;
        bus_if.iLVAL       = 1'b0;
        bus_if.iSW_mode    = 2'd0;
        bus_if.iKEY_apply  = 1'b1;
        wrap_if.iFVAL      = 1'b0;
        wrap_if.iLVAL      = 1'b0;
        wrap_if.iSW_mode   = 2'd0;
        wrap_if.iKEY_apply = 1'b1;

        $display("[TB] start, press latency %0d cycles", PRESS_LAT);
        expect_out(0, 0, 1, 1, 0, 0);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        applyStimulus();

        // Frame counter wrap on the 4-bit instance: 15 -> 0 -> 1
        for (int i = 0; i < 17; i++) begin
            wrap_q.push_back((i + 1) % 16);
            wrap_if.iFVAL = 1'b1;
            tick(2);
            wrap_if.iFVAL = 1'b0;
            tick(2);
        end
        tick(5);

        checks++;
        if (exp_q.size() != 0) begin
            $display("[TB] FAIL out_missing: got %0d expected changes never seen, required 0", exp_q.size());
        end else begin
            passes++;
        end
        checks++;
        if (wrap_q.size() != 0) begin
            $display("[TB] FAIL wrap_missing: got %0d frame count changes never seen, required 0", wrap_q.size());
        end else begin
            passes++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
